// File: rtl/apb_reg_bank.sv
// rtl/apb_reg_bank.sv - APB slave register bank with wait states, byte strobes, error response and a direct side port
module apb_reg_bank #(
   parameter int AMBA_WORD       = 32,
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int DEPTH           = 16,
   parameter int BASE_ADDR       = 0,
   parameter int WAIT_STATES     = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   input  logic [AMBA_WORD-1:0]       PWDATA,
   input  logic [AMBA_WORD/8-1:0]     PSTRB,
   output logic [AMBA_WORD-1:0]       PRDATA,
   output logic                       PREADY,
   output logic                       PSLVERR,
   input  logic                       direct_we,
   input  logic [$clog2(DEPTH)-1:0]   direct_addr,
   input  logic [AMBA_WORD-1:0]       direct_write,
   output logic [AMBA_WORD-1:0]       direct_read
);

   localparam int BYTES = AMBA_WORD / 8;
   localparam int IW    = $clog2(DEPTH);
   localparam int AW    = AMBA_ADDR_WIDTH;
   localparam int AW1   = AMBA_ADDR_WIDTH + 1;
   localparam logic [AW-1:0] BASE   = AW'(BASE_ADDR);
   localparam logic [AW:0]   SPAN   = AW1'(DEPTH * BYTES);
   localparam logic [AW-1:0] WBYTES = AW'(BYTES);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   logic [AMBA_WORD-1:0] mem [DEPTH];
   state_t               state, state_next;
   logic [3:0]           cnt, cnt_next;
   logic [AW-1:0]        offset;
   logic                 addr_valid;
   logic [IW-1:0]        addr_idx;
   logic                 lat_write, lat_valid;
   logic [IW-1:0]        lat_idx;
   logic [AMBA_WORD-1:0] lat_wdata;
   logic [BYTES-1:0]     lat_strb;
   logic                 load, ready_next, sel_valid, sel_write, commit;
   logic [IW-1:0]        sel_idx;

   assign offset     = PADDR - BASE;
   assign addr_valid = (PADDR >= BASE) && ({1'b0, offset} < SPAN) && ((PADDR % WBYTES) == '0);
   assign addr_idx   = IW'(offset / WBYTES);
   assign commit     = PREADY && lat_write && lat_valid;

   // sel_* is the transfer that will be completing when ready_next lands in PREADY
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      load       = 1'b0;
      ready_next = 1'b0;
      sel_valid  = lat_valid;
      sel_write  = lat_write;
      sel_idx    = lat_idx;
      case (state)
         IDLE: begin
            if (PSEL && !PENABLE) state_next = SETUP;
         end
         SETUP: begin
            if (!PSEL) begin
               state_next = IDLE;
            end else begin
               state_next = ACCESS;
               cnt_next   = 4'(WAIT_STATES);
               load       = 1'b1;
               sel_valid  = addr_valid;
               sel_write  = PWRITE;
               sel_idx    = addr_idx;
               ready_next = (WAIT_STATES == 0);
            end
         end
         ACCESS: begin
            if (cnt == 4'd0) begin
               state_next = (PSEL && !PENABLE) ? SETUP : IDLE;
            end else if (!PSEL || !PENABLE) begin
               state_next = IDLE;
               cnt_next   = 4'd0;
            end else begin
               cnt_next   = cnt - 4'd1;
               ready_next = (cnt == 4'd1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         PREADY      <= 1'b0;
         PSLVERR     <= 1'b0;
         PRDATA      <= '0;
         direct_read <= '0;
         lat_write   <= 1'b0;
         lat_valid   <= 1'b0;
         lat_idx     <= '0;
         lat_wdata   <= '0;
         lat_strb    <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         PREADY  <= ready_next;
         PSLVERR <= ready_next && !sel_valid;
         if (ready_next && !sel_write) PRDATA <= sel_valid ? mem[sel_idx] : '0;
         if (load) begin
            lat_write <= PWRITE;
            lat_valid <= addr_valid;
            lat_idx   <= addr_idx;
            lat_wdata <= PWDATA;
            lat_strb  <= PSTRB;
         end
         direct_read <= mem[direct_addr];
         if (direct_we) mem[direct_addr] <= direct_write;
         // later assignment lets strobed APB bytes override a same-edge direct write
         if (commit) begin
            for (int b = 0; b < BYTES; b++)
               if (lat_strb[b]) mem[lat_idx][b*8 +: 8] <= lat_wdata[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_apb_reg_bank.sv
// tb/tb_apb_reg_bank.sv - directed bench for apb_reg_bank at WAIT_STATES 0, 3 and 2
module tb_apb_reg_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  psel;
   logic        penable, pwrite;
   logic [19:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        direct_we;
   logic [3:0]  direct_addr;
   logic [31:0] direct_write;
   logic [31:0] prdata [3];
   logic        pready [3];
   logic        pslverr [3];
   logic [31:0] dread [3];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // instance 0: WAIT_STATES=0, instance 1: 3, instance 2: 2
   for (genvar k = 0; k < 3; k++) begin : g_dut
      apb_reg_bank #(
         .AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DEPTH(16), .BASE_ADDR(0),
         .WAIT_STATES((k == 0) ? 0 : (k == 1) ? 3 : 2)
      ) u_dut (
         .clk(clk), .rst(rst),
         .PSEL(psel[k]), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
         .PWDATA(pwdata), .PSTRB(pstrb),
         .PRDATA(prdata[k]), .PREADY(pready[k]), .PSLVERR(pslverr[k]),
         .direct_we(direct_we), .direct_addr(direct_addr),
         .direct_write(direct_write), .direct_read(dread[k])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input int k, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!pready[k] && lat < 40);
   endtask

   task automatic xfer(input int k, input logic wr, input logic [19:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic coll,
                       output logic [31:0] rd, output logic err, output int lat);
      @(negedge clk);
      psel[k] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      @(negedge clk);
      penable = 1'b1;
      wait_ready(k, lat);
      rd = prdata[k];
      err = pslverr[k];
      psel[k] = 1'b0; penable = 1'b0;
      if (coll) begin
         direct_we = 1'b1; direct_addr = 4'd5; direct_write = 32'h1234_5678;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        err, seen;
      int          lat;

      rst = 1'b0; psel = '0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
      direct_we = 0; direct_addr = '0; direct_write = '0;
      repeat (3) @(negedge clk);
      chk("rst_prdata", prdata[0], 32'h0);
      chk("rst_pready", 32'(pready[0]), 32'h0);
      chk("rst_pslverr", 32'(pslverr[0]), 32'h0);
      chk("rst_dread", dread[0], 32'h0);
      rst = 1'b1;

      xfer(0, 1, 20'h8, 32'hDEAD_BEEF, 4'hF, 0, rd, err, lat);
      chk("w0_write_lat", 32'(lat), 32'd1);
      chk("w0_write_err", 32'(err), 32'h0);
      xfer(0, 0, 20'h8, 32'h0, 4'h0, 0, rd, err, lat);
      chk("w0_read_data", rd, 32'hDEAD_BEEF);
      chk("w0_read_lat", 32'(lat), 32'd1);
      chk("w0_read_err", 32'(err), 32'h0);

      xfer(1, 1, 20'h10, 32'hAAAA_AAAA, 4'hF, 0, rd, err, lat);
      chk("w3_fill_lat", 32'(lat), 32'd4);
      xfer(1, 1, 20'h10, 32'h1122_3344, 4'b0101, 0, rd, err, lat);
      chk("w3_strb_lat", 32'(lat), 32'd4);
      chk("w3_strb_err", 32'(err), 32'h0);
      xfer(1, 0, 20'h10, 32'h0, 4'h0, 0, rd, err, lat);
      chk("w3_strb_data", rd, 32'hAA22_AA44);

      xfer(0, 0, 20'h40, 32'h0, 4'h0, 0, rd, err, lat);
      chk("oob_read_err", 32'(err), 32'h1);
      chk("oob_read_data", rd, 32'h0);
      chk("oob_read_lat", 32'(lat), 32'd1);
      xfer(0, 1, 20'h2, 32'hFFFF_FFFF, 4'hF, 0, rd, err, lat);
      chk("misalign_write_err", 32'(err), 32'h1);
      xfer(0, 0, 20'h0, 32'h0, 4'h0, 0, rd, err, lat);
      chk("misalign_reg0", rd, 32'h0);
      chk("misalign_reg0_err", 32'(err), 32'h0);
      xfer(0, 0, 20'h8, 32'h0, 4'h0, 0, rd, err, lat);
      chk("reg2_kept", rd, 32'hDEAD_BEEF);

      xfer(0, 1, 20'h14, 32'h0000_BEEF, 4'b0011, 1, rd, err, lat);
      chk("coll_err", 32'(err), 32'h0);
      @(negedge clk);
      direct_we = 1'b0;
      chk("coll_dread_old", dread[0], 32'h0);
      @(negedge clk);
      chk("coll_dread_new", dread[0], 32'h1234_BEEF);
      xfer(0, 0, 20'h14, 32'h0, 4'h0, 0, rd, err, lat);
      chk("coll_apb_read", rd, 32'h1234_BEEF);

      @(negedge clk);
      psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h20; pwdata = 32'hA5A5_0001; pstrb = 4'hF;
      @(negedge clk);
      penable = 1'b1;
      wait_ready(0, lat);
      chk("b2b_first_lat", 32'(lat), 32'd1);
      penable = 1'b0; paddr = 20'h24; pwdata = 32'h5A5A_0002;
      @(negedge clk);
      penable = 1'b1;
      wait_ready(0, lat);
      chk("b2b_second_lat", 32'(lat), 32'd1);
      psel[0] = 1'b0; penable = 1'b0;
      xfer(0, 0, 20'h20, 32'h0, 4'h0, 0, rd, err, lat);
      chk("b2b_first_data", rd, 32'hA5A5_0001);
      xfer(0, 0, 20'h24, 32'h0, 4'h0, 0, rd, err, lat);
      chk("b2b_second_data", rd, 32'h5A5A_0002);

      @(negedge clk);
      psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h18; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      penable = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         psel[2] = 1'b0;
         seen = seen | pready[2];
      end
      chk("abort_no_pready", 32'(seen), 32'h0);
      xfer(2, 0, 20'h18, 32'h0, 4'h0, 0, rd, err, lat);
      chk("abort_no_write", rd, 32'h0);
      chk("w2_read_lat", 32'(lat), 32'd3);

      xfer(2, 1, 20'h1C, 32'h55AA_55AA, 4'hF, 0, rd, err, lat);
      chk("w2_write_lat", 32'(lat), 32'd3);
      @(negedge clk);
      psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 20'h1C;
      @(negedge clk);
      penable = 1'b1;
      wait_ready(2, lat);
      chk("pre_rst_prdata", prdata[2], 32'h55AA_55AA);
      chk("pre_rst_pready", 32'(pready[2]), 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_prdata", prdata[2], 32'h0);
      chk("mid_rst_pready", 32'(pready[2]), 32'h0);
      chk("mid_rst_pslverr", 32'(pslverr[2]), 32'h0);
      psel[2] = 1'b0; penable = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      xfer(2, 0, 20'h1C, 32'h0, 4'h0, 0, rd, err, lat);
      chk("post_rst_reg7", rd, 32'h0);
      chk("post_rst_lat", 32'(lat), 32'd3);
      xfer(0, 0, 20'h8, 32'h0, 4'h0, 0, rd, err, lat);
      chk("post_rst_inst0_reg2", rd, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
